// File: rtl/pe_slave_adapter.sv
// Slave-side adapter between the peripheral crossbar and a single in-order peripheral.
// Requests pass through combinationally; master IDs are queued and re-attached to registered responses.
module pe_slave_adapter #(
  parameter int ID_WIDTH   = 16,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1,
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [5:0]            data_atop_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  output logic                  data_gnt_o,

  output logic                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic [ID_WIDTH-1:0]   data_r_ID_o,
  output logic                  data_r_opc_o,

  output logic                  per_req_o,
  output logic [ADDR_WIDTH-1:0] per_add_o,
  output logic                  per_wen_o,
  output logic [5:0]            per_atop_o,
  output logic [DATA_WIDTH-1:0] per_wdata_o,
  output logic [BE_WIDTH-1:0]   per_be_o,
  input  logic                  per_gnt_i,
  input  logic                  per_r_valid_i,
  input  logic [DATA_WIDTH-1:0] per_r_rdata_i,
  input  logic                  per_r_opc_i,

  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  err_unexp_o
);

  logic [CNT_WIDTH-1:0] count;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [ID_WIDTH-1:0]  id_mem [FIFO_DEPTH];
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign full  = (count == CNT_WIDTH'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign per_add_o   = data_add_i;
  assign per_wen_o   = data_wen_i;
  assign per_atop_o  = data_atop_i;
  assign per_wdata_o = data_wdata_i;
  assign per_be_o    = data_be_i;

  // A pop in the same cycle never frees a slot early: full blocks the request outright.
  assign per_req_o  = data_req_i & ~full;
  assign data_gnt_o = per_gnt_i & per_req_o;

  // Emptiness is judged before this cycle's push, so a response racing its own grant is unexpected.
  assign push = per_req_o & per_gnt_i;
  assign pop  = per_r_valid_i & ~empty;

  assign outstanding_o = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      if (push && !pop)      count <= count + CNT_WIDTH'(1);
      else if (pop && !push) count <= count - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= data_ID_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r_valid_o <= 1'b0;
      data_r_rdata_o <= '0;
      data_r_ID_o    <= '0;
      data_r_opc_o   <= 1'b0;
      err_unexp_o    <= 1'b0;
    end else begin
      data_r_valid_o <= pop;
      if (pop) begin
        data_r_rdata_o <= per_r_rdata_i;
        data_r_ID_o    <= id_mem[rd_ptr];
        data_r_opc_o   <= per_r_opc_i;
      end
      if (per_r_valid_i && empty) err_unexp_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_slave_adapter.sv
// Self-checking bench for pe_slave_adapter: directed scenarios plus randomized traffic
// compared each cycle against a queue-based model of the outstanding master IDs.
module tb_pe_slave_adapter;
  localparam int ID_W   = 16;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int BE_W   = DATA_W / 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              data_req_i;
  logic [ADDR_W-1:0] data_add_i;
  logic              data_wen_i;
  logic [5:0]        data_atop_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic [BE_W-1:0]   data_be_i;
  logic [ID_W-1:0]   data_ID_i;
  logic              data_gnt_o;
  logic              data_r_valid_o;
  logic [DATA_W-1:0] data_r_rdata_o;
  logic [ID_W-1:0]   data_r_ID_o;
  logic              data_r_opc_o;
  logic              per_req_o;
  logic [ADDR_W-1:0] per_add_o;
  logic              per_wen_o;
  logic [5:0]        per_atop_o;
  logic [DATA_W-1:0] per_wdata_o;
  logic [BE_W-1:0]   per_be_o;
  logic              per_gnt_i;
  logic              per_r_valid_i;
  logic [DATA_W-1:0] per_r_rdata_i;
  logic              per_r_opc_i;
  logic [CNT_W-1:0]  outstanding_o;
  logic              err_unexp_o;

  pe_slave_adapter #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_atop_i(data_atop_i), .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_ID_i(data_ID_i), .data_gnt_o(data_gnt_o),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
    .data_r_ID_o(data_r_ID_o), .data_r_opc_o(data_r_opc_o),
    .per_req_o(per_req_o), .per_add_o(per_add_o), .per_wen_o(per_wen_o),
    .per_atop_o(per_atop_o), .per_wdata_o(per_wdata_o), .per_be_o(per_be_o),
    .per_gnt_i(per_gnt_i), .per_r_valid_i(per_r_valid_i),
    .per_r_rdata_i(per_r_rdata_i), .per_r_opc_i(per_r_opc_i),
    .outstanding_o(outstanding_o), .err_unexp_o(err_unexp_o)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  // Model: IDs granted but not yet answered, in issue order, plus the expected response registers.
  logic [ID_W-1:0]   id_q[$];
  logic              exp_err;
  logic              exp_valid;
  logic [DATA_W-1:0] exp_rdata;
  logic [ID_W-1:0]   exp_id;
  logic              exp_opc;
  logic              model_gnt;
  logic              seen_req;
  logic              seen_gnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    id_q.delete();
    exp_err   = 1'b0;
    exp_valid = 1'b0;
    exp_rdata = '0;
    exp_id    = '0;
    exp_opc   = 1'b0;
  endtask

  task automatic checkOutput();
    check("r_valid", 64'(data_r_valid_o), 64'(exp_valid));
    check("r_rdata", 64'(data_r_rdata_o), 64'(exp_rdata));
    check("r_id", 64'(data_r_ID_o), 64'(exp_id));
    check("r_opc", 64'(data_r_opc_o), 64'(exp_opc));
    check("outstanding", 64'(outstanding_o), 64'(id_q.size()));
    check("err_unexp", 64'(err_unexp_o), 64'(exp_err));
  endtask

  // One clock cycle: drive at posedge+1, check combinational paths and advance the model, then check registers.
  task automatic applyStimulus(input logic req, input logic [ID_W-1:0] id, input logic gnt,
                               input logic rvalid, input logic [DATA_W-1:0] rdata, input logic opc);
    logic exp_req;
    logic do_pop;
    data_req_i    = req;
    data_ID_i     = id;
    data_add_i    = ADDR_W'($urandom);
    data_wen_i    = 1'($urandom);
    data_atop_i   = 6'($urandom);
    data_wdata_i  = $urandom;
    data_be_i     = BE_W'($urandom);
    per_gnt_i     = gnt;
    per_r_valid_i = rvalid;
    per_r_rdata_i = rdata;
    per_r_opc_i   = opc;
    #2;
    exp_req   = req && (id_q.size() != DEPTH);
    model_gnt = exp_req && gnt;
    seen_req  = per_req_o;
    seen_gnt  = data_gnt_o;
    check("per_req", 64'(per_req_o), 64'(exp_req));
    check("data_gnt", 64'(data_gnt_o), 64'(model_gnt));
    check("passthru_ctl", 64'({per_add_o, per_wen_o, per_atop_o, per_be_o}),
          64'({data_add_i, data_wen_i, data_atop_i, data_be_i}));
    check("passthru_wdata", 64'(per_wdata_o), 64'(data_wdata_i));
    do_pop = rvalid && (id_q.size() != 0);
    if (rvalid && id_q.size() == 0) exp_err = 1'b1;
    exp_valid = do_pop;
    if (do_pop) begin
      exp_id    = id_q.pop_front();
      exp_rdata = rdata;
      exp_opc   = opc;
    end
    if (model_gnt) id_q.push_back(id);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic doReset();
    rst_n         = 1'b0;
    data_req_i    = 1'b1;
    per_gnt_i     = 1'b0;
    per_r_valid_i = 1'b0;
    #1;
    clearModel();
    check("rst_req_follows", 64'(per_req_o), 64'd1);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    data_req_i = 1'b0;
  endtask

  initial begin
    int issued;
    int returned;
    int budget;
    logic [ID_W-1:0] rid;

    rst_n = 1'b1;
    data_req_i = 1'b0; data_add_i = '0; data_wen_i = 1'b0; data_atop_i = '0;
    data_wdata_i = '0; data_be_i = '0; data_ID_i = '0;
    per_gnt_i = 1'b0; per_r_valid_i = 1'b0; per_r_rdata_i = '0; per_r_opc_i = 1'b0;
    clearModel();
    #3;
    doReset();

    // Single load with a response two cycles after the grant.
    applyStimulus(1'b1, 16'h0004, 1'b1, 1'b0, '0, 1'b0);
    check("single_gnt", 64'(seen_gnt), 64'd1);
    idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    check("single_valid", 64'(data_r_valid_o), 64'd1);
    check("single_rdata", 64'(data_r_rdata_o), 64'hDEADBEEF);
    check("single_id", 64'(data_r_ID_o), 64'h0004);
    check("single_opc", 64'(data_r_opc_o), 64'd0);
    idle();
    check("single_valid_drop", 64'(data_r_valid_o), 64'd0);

    // Fill to depth, then show a full FIFO refuses requests even while a response pops.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, ID_W'(1 << i), 1'b1, 1'b0, '0, 1'b0);
    check("fill_count", 64'(outstanding_o), 64'd4);
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, '0, 1'b0);
    check("fill_req_blocked", 64'(seen_req), 64'd0);
    check("fill_gnt_blocked", 64'(seen_gnt), 64'd0);
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b1, 32'h12345678, 1'b1);
    check("fill_gnt_on_pop", 64'(seen_gnt), 64'd0);
    check("fill_first_id", 64'(data_r_ID_o), 64'h0001);
    check("fill_count_3", 64'(outstanding_o), 64'd3);
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, '0, 1'b0);
    check("fill_fifth_gnt", 64'(seen_gnt), 64'd1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, $urandom, 1'($urandom));
    check("fill_drained", 64'(outstanding_o), 64'd0);

    // Simultaneous push and pop with two outstanding.
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 16'h0200, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 16'h0400, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0);
    check("simul_count", 64'(outstanding_o), 64'd2);
    check("simul_id", 64'(data_r_ID_o), 64'h0100);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b0);

    // Unexpected response, including one racing a push into the empty FIFO.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b1);
    check("unexp_no_valid", 64'(data_r_valid_o), 64'd0);
    check("unexp_err", 64'(err_unexp_o), 64'd1);
    applyStimulus(1'b1, 16'h0008, 1'b1, 1'b1, 32'h0, 1'b0);
    check("unexp_race_count", 64'(outstanding_o), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h55AA55AA, 1'b0);
    check("unexp_race_id", 64'(data_r_ID_o), 64'h0008);
    idle();
    check("unexp_sticky", 64'(err_unexp_o), 64'd1);

    // Reset with three in flight, then a normal request.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, ID_W'(2 << i), 1'b1, 1'b0, '0, 1'b0);
    check("rst_pre_count", 64'(outstanding_o), 64'd3);
    doReset();
    check("rst_err_clear", 64'(err_unexp_o), 64'd0);
    applyStimulus(1'b1, 16'h8000, 1'b1, 1'b0, '0, 1'b0);
    check("rst_next_gnt", 64'(seen_gnt), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);
    check("rst_next_id", 64'(data_r_ID_o), 64'h8000);

    // Ten one-hot IDs with random grant and response gaps must come back in issue order.
    issued = 0; returned = 0; budget = 600;
    while ((issued < 10 || id_q.size() != 0) && budget > 0) begin
      rid = ID_W'(1 << issued);
      applyStimulus(issued < 10 && $urandom_range(0, 1) == 1, rid, $urandom_range(0, 2) != 0,
                    id_q.size() != 0 && $urandom_range(0, 2) == 0, $urandom, 1'($urandom));
      if (model_gnt) issued++;
      if (exp_valid) begin
        check("order_id", 64'(data_r_ID_o), 64'(1 << returned));
        returned++;
      end
      budget--;
    end
    if (budget == 0) begin
      assertions++; failures++;
      $display("[TB] FAIL order_timeout: got %0d issued, expected 10 issued and drained", issued);
    end
    check("order_final_count", 64'(outstanding_o), 64'd0);

    // Free-running random traffic, occasional unexpected responses when empty.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, ID_W'(1 << $urandom_range(0, ID_W - 1)),
                    $urandom_range(0, 3) != 0,
                    (id_q.size() != 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 49) == 0),
                    $urandom, 1'($urandom));
    end
    budget = 20;
    while (id_q.size() != 0 && budget > 0) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, $urandom, 1'($urandom));
      budget--;
    end
    check("random_drained", 64'(outstanding_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
